// File: rtl/sign_contr.sv
// Two-road traffic signal controller: highway green by default, country road served on demand.
// Latency: one CLOCK from sensor sample to lamp change; yellow/all-red dwells set by parameters.
// No backpressure: free-running Moore machine, sensor sampled every edge, lamps always driven.

`ifndef TRUE
`define TRUE (1'b1)
`endif
`ifndef FALSE
`define FALSE (1'b0)
`endif

module sign_contr #(
  parameter int Y2R_DELAY = 3,  // cycles in each yellow state, >= 1
  parameter int R2G_DELAY = 2   // cycles in the all-red state, >= 1
) (
  output logic [1:0] MAIN_SIG,
  output logic [1:0] CNTRY_SIG,
  input  logic       CAR_ON_CNTRY_RD,
  input  logic       CLOCK,
  input  logic       CLEAR
);

  // Lamp encoding shared by both signal heads; 2'b11 is never produced.
  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  // The counter only ever needs to reach delay-1 of the longest timed state.
  localparam int MAX_DELAY = (Y2R_DELAY > R2G_DELAY) ? Y2R_DELAY : R2G_DELAY;
  localparam int CW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  localparam logic [CW-1:0] Y2R_LAST = CW'(Y2R_DELAY - 1);
  localparam logic [CW-1:0] R2G_LAST = CW'(R2G_DELAY - 1);

  typedef enum logic [2:0] {
    S0_MAIN_GREEN   = 3'd0,  // GREEN / RED
    S1_MAIN_YELLOW  = 3'd1,  // YELLOW / RED
    S2_ALL_RED      = 3'd2,  // RED / RED
    S3_CNTRY_GREEN  = 3'd3,  // RED / GREEN
    S4_CNTRY_YELLOW = 3'd4   // RED / YELLOW
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      main_q, main_d;
  logic [1:0]      cntry_q, cntry_d;

  // Next state and dwell count; the count restarts from zero whenever the state changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S0_MAIN_GREEN: begin
        if (CAR_ON_CNTRY_RD == `TRUE) state_d = S1_MAIN_YELLOW;
      end
      S1_MAIN_YELLOW: begin
        if (cnt_q == Y2R_LAST) state_d = S2_ALL_RED;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S2_ALL_RED: begin
        if (cnt_q == R2G_LAST) state_d = S3_CNTRY_GREEN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S3_CNTRY_GREEN: begin
        // No maximum green: the country road keeps it while cars are present.
        if (CAR_ON_CNTRY_RD == `FALSE) state_d = S4_CNTRY_YELLOW;
      end
      S4_CNTRY_YELLOW: begin
        // A car arriving here waits for S0; the sensor is not looked at.
        if (cnt_q == Y2R_LAST) state_d = S0_MAIN_GREEN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S0_MAIN_GREEN;  // recover from unused encodings
    endcase
    // Clear overrides every transition and holds the highway green.
    if (CLEAR) begin
      state_d = S0_MAIN_GREEN;
      cnt_d   = '0;
    end
  end

  // Lamp decode of the upcoming state, so the lamp registers always mirror the state register.
  always_comb begin
    main_d  = LAMP_RED;
    cntry_d = LAMP_RED;
    unique case (state_d)
      S0_MAIN_GREEN:   main_d  = LAMP_GREEN;
      S1_MAIN_YELLOW:  main_d  = LAMP_YELLOW;
      S2_ALL_RED:      ;
      S3_CNTRY_GREEN:  cntry_d = LAMP_GREEN;
      S4_CNTRY_YELLOW: cntry_d = LAMP_YELLOW;
      default:         ;
    endcase
  end

  // State, dwell counter and registered lamp outputs; CLEAR is folded into the next-state logic.
  always_ff @(posedge CLOCK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    main_q  <= main_d;
    cntry_q <= cntry_d;
  end

  assign MAIN_SIG  = main_q;
  assign CNTRY_SIG = cntry_q;

endmodule

// File: tb/tb_sign_contr.sv
// Directed bench for sign_contr: each step queues the lamp pair expected after the next edge,
// then pops it and compares once the edge has produced the outputs.
// A negedge monitor checks the never-both-non-red and never-2'b11 rules on every cycle.

module tb_sign_contr;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] YL = 2'b01;
  localparam logic [1:0] GN = 2'b10;

  logic       CLOCK = 1'b0;
  logic       CLEAR;
  logic       car;
  logic [1:0] main_sig;
  logic [1:0] cntry_sig;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  sign_contr #(.Y2R_DELAY(3), .R2G_DELAY(2)) dut (
    .MAIN_SIG        (main_sig),
    .CNTRY_SIG       (cntry_sig),
    .CAR_ON_CNTRY_RD (car),
    .CLOCK           (CLOCK),
    .CLEAR           (CLEAR)
  );

  always #5 CLOCK = ~CLOCK;

  // One clock step: drive inputs, queue the expectation, pop and check after the edge.
  task automatic cyc(input logic c, input logic clr, input logic [1:0] em, input logic [1:0] ec,
                     input string tag);
    logic [3:0] exp_v;
    string      t;
    car   = c;
    CLEAR = clr;
    exp_q.push_back({em, ec});
    tag_q.push_back(tag);
    @(posedge CLOCK);
    #1;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    n_cmp++;
    assert ({main_sig, cntry_sig} === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed main/cntry %b/%b required %b/%b", t, main_sig, cntry_sig,
             exp_v[3:2], exp_v[1:0]);
    end
    @(negedge CLOCK);
  endtask

  // A full service: sensor high for hi cycles from S0, then the country yellow with sensor ycar.
  task automatic request(input int hi, input logic ycar, input string tag);
    int n;
    n = (hi > 6) ? hi : 6;
    for (int i = 0; i < n; i++) begin
      if (i < 3)      cyc(i < hi, 1'b0, YL, RD, tag);
      else if (i < 5) cyc(i < hi, 1'b0, RD, RD, tag);
      else            cyc(i < hi, 1'b0, RD, GN, tag);
    end
    cyc(1'b0, 1'b0, RD, YL, tag);
    cyc(ycar, 1'b0, RD, YL, tag);
    cyc(ycar, 1'b0, RD, YL, tag);
    cyc(ycar, 1'b0, GN, RD, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, GN, RD, tag);
  endtask

  // Safety rules, checked away from the active edge once reset has been applied.
  always @(negedge CLOCK) begin
    if (armed) begin
      n_cmp++;
      assert (!((main_sig != RD) && (cntry_sig != RD)) && (main_sig != 2'b11) &&
              (cntry_sig != 2'b11)) else begin
        n_bad++;
        $error("FAIL safety: observed main/cntry %b/%b required at least one 00 and no 11",
               main_sig, cntry_sig);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    CLEAR = 1'b1;
    car   = 1'b0;

    // Reset for 5 edges, then 15 quiet cycles: highway green throughout.
    cyc(1'b0, 1'b1, GN, RD, "reset");
    armed = 1'b1;
    repeat (4) cyc(1'b0, 1'b1, GN, RD, "reset");
    idle(15, "idle_after_reset");

    // Sensor high 200-300 ns, then 500-600 and 800-900 ns; stop at 1000 ns on highway green.
    request(10, 1'b0, "cycle1");
    idle(16, "idle1");
    request(10, 1'b0, "cycle2");
    idle(16, "idle2");
    request(10, 1'b0, "cycle3");
    idle(6, "idle3");

    // Sensor drops during S1: sequence still reaches S3, then leaves on the next edge.
    request(1, 1'b0, "s1_drop");
    idle(2, "idle4");

    // Sensor rises during S4: S0 is entered first, next request then starts from S0.
    request(6, 1'b1, "s4_rise");
    request(6, 1'b0, "after_s4");
    idle(2, "idle5");

    // CLEAR held with a car waiting: stays in S0.
    repeat (3) cyc(1'b1, 1'b1, GN, RD, "clear_hold");
    cyc(1'b0, 1'b0, GN, RD, "clear_hold_rel");

    // Reset one cycle into S2, then a full-length request.
    repeat (3) cyc(1'b1, 1'b0, YL, RD, "pre_rst_s2");
    cyc(1'b1, 1'b0, RD, RD, "pre_rst_s2");
    cyc(1'b1, 1'b1, GN, RD, "rst_s2");
    request(7, 1'b0, "after_rst_s2");

    // Reset two cycles into S1 (dwell count mid-way), then a full-length request.
    repeat (2) cyc(1'b1, 1'b0, YL, RD, "pre_rst_s1");
    cyc(1'b0, 1'b1, GN, RD, "rst_s1");
    idle(1, "idle6");
    request(6, 1'b0, "after_rst_s1");

    // Reset during S3 with the car still present, then it is served again from S0.
    repeat (3) cyc(1'b1, 1'b0, YL, RD, "pre_rst_s3");
    repeat (2) cyc(1'b1, 1'b0, RD, RD, "pre_rst_s3");
    repeat (2) cyc(1'b1, 1'b0, RD, GN, "pre_rst_s3");
    cyc(1'b1, 1'b1, GN, RD, "rst_s3");
    request(6, 1'b0, "after_rst_s3");

    // Reset in S4, then quiet.
    request(6, 1'b0, "pre_rst_s4_a");
    repeat (3) cyc(1'b1, 1'b0, YL, RD, "pre_rst_s4");
    repeat (2) cyc(1'b1, 1'b0, RD, RD, "pre_rst_s4");
    cyc(1'b1, 1'b0, RD, GN, "pre_rst_s4");
    cyc(1'b0, 1'b0, RD, YL, "pre_rst_s4");
    cyc(1'b0, 1'b1, GN, RD, "rst_s4");
    idle(4, "idle_end");

    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sign_contr.md
# sign_contr

Two-road traffic signal controller: a main highway and a country road crossing it. The highway holds green by default. A car detected on the country road makes the block sequence the highway through yellow and red, then give the country road green. When the country road empties, it sequences back. Moore-style FSM with a dwell-time counter, clocked from the system clock; it drives the two lamp-encoding buses to the signal heads.

## Interface
- Y2R_DELAY, default 3: clock cycles spent in each yellow state (highway yellow, country yellow); legal range ≥1.
- R2G_DELAY, default 2: clock cycles spent in the all-red state before country green; legal range ≥1.
- CLOCK  input  1  sole clock; all state changes on its rising edge.
- CLEAR  input  1  reset; synchronous, active-high.
- CAR_ON_CNTRY_RD  input  1  car-present sensor for the country road; 1 = car waiting, sampled at rising CLOCK.
- MAIN_SIG  output  2  highway lamp: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN.
- CNTRY_SIG  output  2  country-road lamp, same encoding.
- Positional port order: MAIN_SIG, CNTRY_SIG, CAR_ON_CNTRY_RD, CLOCK, CLEAR.
- The source file globally defines the macros `TRUE (1'b1) and `FALSE (1'b0) for use by surrounding code and benches. Guard each with `ifndef.
- Encoding 2'b11 is never driven.

## Operation
- States and their outputs (MAIN/CNTRY):
  - S0 = GREEN/RED
  - S1 = YELLOW/RED
  - S2 = RED/RED
  - S3 = RED/GREEN
  - S4 = RED/YELLOW
- Outputs are a pure decode of the state register. No combinational path from CAR_ON_CNTRY_RD to the outputs.
- Transitions, evaluated at each rising CLOCK when CLEAR=0:
  - S0: CAR_ON_CNTRY_RD=1 → S1; else stay.
  - S1: stay exactly Y2R_DELAY cycles, then → S2. Sensor ignored.
  - S2: stay exactly R2G_DELAY cycles, then → S3. Sensor ignored.
  - S3: CAR_ON_CNTRY_RD=0 → S4; else stay. No maximum green time.
  - S4: stay exactly Y2R_DELAY cycles, then → S0. Sensor ignored. A car arriving during S4 is served only after S0 is re-entered.
- Dwell counter:
  - Cleared on every state change; increments each cycle in a timed state.
  - Transition fires on the edge where the counter equals delay−1.
  - Counter width is sufficient for max(Y2R_DELAY, R2G_DELAY).
- Safety invariant: the two roads are never both non-RED. Every change between a GREEN on one road and a GREEN on the other passes through a YELLOW state.

## Timing
- Reset:
  - Any rising CLOCK with CLEAR=1 forces state S0 and dwell counter 0.
  - MAIN_SIG=2'b10 and CNTRY_SIG=2'b00 from that edge.
  - Applies mid-sequence from any state, and takes priority over all transitions.
  - While CLEAR stays 1, the block holds S0 regardless of the sensor.
- Before the first reset edge, the state is undefined. Benches assert CLEAR from time 0.
- Sensor latency: the sensor rises before edge N → S1 outputs are visible after edge N (1 cycle).
- Dwell times with default parameters:
  - S1 for 3 cycles.
  - S2 for 2 cycles.
  - Country green begins 5 cycles after S1 entry.
  - S4 for 3 cycles.
- Sensor falls before edge M while in S3 → S4 from edge M; S0 from edge M+3.
- A sensor pulse shorter than one cycle that is not high at a rising edge is missed. This is acceptable.

## Test plan
- Reset:
  - CLEAR=1 for 5 cycles with the sensor at 0 → MAIN=10, CNTRY=00 from the first edge.
  - After deassertion with the sensor held 0, the outputs remain 10/00 for 15 further cycles.
- Full cycle (10 ns clock, rising edges at 5+10k ns, CLEAR released at 45 ns):
  - Sensor 1 at 200 ns → MAIN=01 at 205.
  - MAIN=00/CNTRY=00 at 235.
  - CNTRY=10 at 255.
  - Sensor 0 at 300 → CNTRY=01 at 305.
  - MAIN=10/CNTRY=00 at 335.
- Repeat cycles: sensor pulses 500–600 ns and 800–900 ns → the identical sequence offset by 300 ns and 600 ns. Stop at 1000 ns with MAIN=10.
- Sensor ignored in timed states:
  - Sensor drops during S1 → sequence still reaches S3, then leaves to S4 on the next edge.
  - Sensor rises during S4 → S0 is entered, then S1 on the following edge.
- Mid-sequence reset: CLEAR pulsed for 1 cycle while in S2 or S3 → MAIN=10, CNTRY=00 on that edge. The counter restarts, and the next request yields full-length dwells.
- Safety assertion over all runs: never (MAIN≠00 and CNTRY≠00), and never 2'b11 on either output.
